// File: rtl/imem_sram_resp.sv
// imem_sram_resp: instruction-memory responder in front of a 1-cycle SRAM.
// Checks fetches, reads the SRAM, and returns in-order responses via a 3-deep FIFO.

package imem_sram_resp_pkg;

    typedef enum logic [1:0] {
        MEM_READ  = 2'd0,
        MEM_WRITE = 2'd1,
        MEM_AMO   = 2'd2,
        MEM_FENCE = 2'd3
    } mem_type_t;

    typedef struct packed {
        mem_type_t   req_type;
        logic [31:0] req_addr;
    } mem_req_t;

endpackage

module imem_sram_resp
    import imem_sram_resp_pkg::*;
#(
    parameter int          ADDR_W    = 14,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              imem_req_valid,
    output logic              imem_req_ready,
    input  mem_req_t          imem_req,
    output logic              imem_resp_valid,
    input  logic              imem_resp_ready,
    output logic [31:0]       imem_resp_addr,
    output logic [31:0]       imem_resp_data,
    output logic              imem_resp_err,
    output logic              sram_en,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [31:0]       sram_rdata
);

    // 33-bit window bounds so BASE + span cannot wrap past 2^32
    localparam logic [32:0] BASE_X  = {1'b0, BASE_ADDR};
    localparam logic [32:0] SPAN_X  = 33'd4 << ADDR_W;
    localparam logic [32:0] LIMIT_X = BASE_X + SPAN_X;

    logic [32:0] addr_x;
    logic [31:0] offset;
    logic        legal;
    logic        req_fire;

    logic        s1_valid;
    logic [31:0] s1_addr;
    logic        s1_err;

    logic [31:0] fifo_addr [3];
    logic [31:0] fifo_data [3];
    logic        fifo_err  [3];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [1:0]  count;
    logic [2:0]  occupancy;

    logic        push;
    logic        pop;

    assign addr_x = {1'b0, imem_req.req_addr};
    assign offset = imem_req.req_addr - BASE_ADDR;

    // Request legality: aligned read inside the SRAM window
    always_comb begin
        legal = 1'b0;
        if (imem_req.req_type == MEM_READ &&
            imem_req.req_addr[1:0] == 2'b00 &&
            addr_x >= BASE_X &&
            addr_x < LIMIT_X) begin
            legal = 1'b1;
        end
    end

    // Credits count both buffered entries and the read still in S1, so the
    // FIFO can never be over-committed; resp_ready deliberately not used here
    assign occupancy      = {1'b0, count} + {2'b00, s1_valid};
    assign imem_req_ready = ~rst & ~flush & (occupancy < 3'd3);
    assign req_fire       = imem_req_valid & imem_req_ready;

    // SRAM read issue in the accept cycle, only for legal requests
    always_comb begin
        sram_en   = 1'b0;
        sram_addr = '0;
        if (req_fire && legal) begin
            sram_en   = 1'b1;
            sram_addr = offset[ADDR_W+1:2];
        end
    end

    // S1 holds the accepted request while the SRAM read is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_err   <= 1'b0;
        end else begin
            s1_valid <= req_fire & ~flush;
            if (req_fire) begin
                s1_addr <= imem_req.req_addr;
                s1_err  <= ~legal;
            end
        end
    end

    assign push = s1_valid & ~flush & ~rst;
    assign pop  = imem_resp_valid & imem_resp_ready;

    // FIFO storage: S1 lands here with SRAM data, zeroed for errors
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= s1_addr;
            fifo_data[wr_ptr] <= s1_err ? 32'h0 : sram_rdata;
            fifo_err[wr_ptr]  <= s1_err;
        end
    end

    // FIFO pointers and occupancy; flush and reset empty it at once
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (!push && pop) begin
                count <= count - 2'd1;
            end
        end
    end

    // Response port driven from the head; payload forced to 0 when idle
    always_comb begin
        imem_resp_valid = (count != 2'd0) & ~flush & ~rst;
        imem_resp_addr  = 32'h0;
        imem_resp_data  = 32'h0;
        imem_resp_err   = 1'b0;
        if (imem_resp_valid) begin
            imem_resp_addr = fifo_addr[rd_ptr];
            imem_resp_data = fifo_data[rd_ptr];
            imem_resp_err  = fifo_err[rd_ptr];
        end
    end

    // The credit rule makes a push into a full FIFO impossible
    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst || flush)
        !(push && !pop && count == 2'd3)
    );

endmodule

// File: tb/tb_imem_sram_resp.sv
// tb_imem_sram_resp: directed plus random stimulus for imem_sram_resp,
// checked against a transaction-queue model of the responder.

module tb_imem_sram_resp;
    import imem_sram_resp_pkg::*;

    localparam int          ADDR_W = 14;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam longint      SPAN   = 4 * (longint'(1) << ADDR_W);

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              imem_req_valid;
    logic              imem_req_ready;
    mem_req_t          imem_req;
    logic              imem_resp_valid;
    logic              imem_resp_ready;
    logic [31:0]       imem_resp_addr;
    logic [31:0]       imem_resp_data;
    logic              imem_resp_err;
    logic              sram_en;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_rdata;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    imem_sram_resp #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req        (imem_req),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_ready (imem_resp_ready),
        .imem_resp_addr  (imem_resp_addr),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .sram_en         (sram_en),
        .sram_addr       (sram_addr),
        .sram_rdata      (sram_rdata)
    );

    function automatic logic [31:0] word(input logic [ADDR_W-1:0] i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // SRAM: 1-cycle read; garbage on cycles without a read
    always @(posedge clk) begin
        if (sram_en) sram_rdata <= word(sram_addr);
        else         sram_rdata <= $urandom();
    end

    function automatic logic is_legal(input mem_type_t ty, input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (ty == MEM_READ) && (a[1:0] == 2'b00) && (off >= 0) && (off < SPAN);
    endfunction

    function automatic logic [ADDR_W-1:0] widx(input logic [31:0] a);
        longint off;
        off = (longint'(a) - longint'(BASE)) >>> 2;
        return off[ADDR_W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input logic v, input mem_type_t ty, input logic [31:0] a,
                        input logic rr, input logic fl, input logic rs);
        logic exp_ready, exp_valid, fire, leg;
        exp_t e;
        imem_req_valid     = v;
        imem_req.req_type  = ty;
        imem_req.req_addr  = a;
        imem_resp_ready    = rr;
        flush              = fl;
        rst                = rs;
        @(negedge clk);
        exp_ready = !rs && !fl && (q.size() < 3);
        exp_valid = !rs && !fl && (q.size() > 0) && (q[0].acc + 2 <= cyc);
        fire      = v && exp_ready;
        leg       = is_legal(ty, a);
        chk("req_ready", 32'(imem_req_ready), 32'(exp_ready));
        chk("resp_valid", 32'(imem_resp_valid), 32'(exp_valid));
        chk("sram_en", 32'(sram_en), 32'(fire && leg));
        chk("sram_addr", 32'(sram_addr), (fire && leg) ? 32'(widx(a)) : 32'h0);
        if (exp_valid) begin
            chk("resp_addr", imem_resp_addr, q[0].addr);
            chk("resp_data", imem_resp_data, q[0].data);
            chk("resp_err", 32'(imem_resp_err), 32'(q[0].err));
        end
        if (rs) begin
            chk("rst_addr", imem_resp_addr, 32'h0);
            chk("rst_data", imem_resp_data, 32'h0);
            chk("rst_err", 32'(imem_resp_err), 32'h0);
        end
        if (rs || fl) begin
            q.delete();
        end else begin
            if (exp_valid && rr) void'(q.pop_front());
            if (fire) begin
                e.addr = a;
                e.err  = !leg;
                e.data = leg ? word(widx(a)) : 32'h0;
                e.acc  = cyc;
                q.push_back(e);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rr, input int n);
        for (int i = 0; i < n; i++) step(1'b0, MEM_READ, 32'h0, rr, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a, input logic rr);
        step(1'b1, MEM_READ, a, rr, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0: return BASE + 32'(SPAN);
            1: return BASE - 32'd4;
            2: return BASE + 32'(SPAN) - 32'd4;
            3: return BASE + ($urandom_range(0, 32'(SPAN) - 1) | 32'h1);
            4: return $urandom();
            default: return BASE + ($urandom_range(0, (1 << ADDR_W) - 1) << 2);
        endcase
    endfunction

    initial begin
        imem_req_valid  = 1'b0;
        imem_req        = '0;
        imem_resp_ready = 1'b1;
        flush           = 1'b0;
        rst             = 1'b1;
        @(posedge clk);
        #1;

        // reset for 2 cycles, then a single legal fetch
        step(1'b1, MEM_READ, 32'h8000_0010, 1'b1, 1'b0, 1'b1);
        step(1'b1, MEM_READ, 32'h8000_0010, 1'b1, 1'b0, 1'b1);
        rd(32'h8000_0010, 1'b1);
        idle(1'b1, 3);

        // streaming, 16 back-to-back
        for (int i = 0; i < 16; i++) rd(BASE + 32'(i * 4), 1'b1);
        idle(1'b1, 3);

        // back-pressure: 5-cycle stall mid-stream
        for (int i = 0; i < 4; i++) rd(BASE + 32'h200 + 32'(i * 4), 1'b1);
        for (int i = 0; i < 5; i++) rd(BASE + 32'h300 + 32'(i * 4), 1'b0);
        for (int i = 0; i < 6; i++) rd(BASE + 32'h400 + 32'(i * 4), 1'b1);
        idle(1'b1, 4);

        // illegal requests mixed with legal ones
        rd(32'h8000_0002, 1'b1);
        rd(32'h8000_0020, 1'b1);
        rd(BASE + 32'(SPAN), 1'b1);
        rd(32'h7FFF_FFFC, 1'b1);
        step(1'b1, MEM_WRITE, 32'h8000_0024, 1'b1, 1'b0, 1'b0);
        rd(BASE + 32'(SPAN) - 32'd4, 1'b1);
        step(1'b1, MEM_FENCE, 32'h8000_0028, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 4);

        // flush with the responder full
        for (int i = 0; i < 5; i++) rd(BASE + 32'h40 + 32'(i * 4), 1'b0);
        step(1'b1, MEM_READ, 32'h8000_0080, 1'b1, 1'b1, 1'b0);
        rd(32'h8000_0100, 1'b1);
        idle(1'b1, 4);

        // reset with 2 responses buffered
        rd(BASE + 32'h500, 1'b0);
        rd(BASE + 32'h504, 1'b0);
        idle(1'b0, 2);
        step(1'b1, MEM_READ, 32'h8000_0508, 1'b1, 1'b0, 1'b1);
        idle(1'b1, 4);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 5) == 0) ? mem_type_t'($urandom_range(1, 3)) : MEM_READ,
                 rand_addr(),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 40) == 0,
                 $urandom_range(0, 150) == 0);
        end
        idle(1'b1, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
